// File: rtl/ud_bounded_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ud_bounded_counter: up/down counter with preset, load, step and min/max    |
// | bounds that either wrap or clamp.            Revision: 1.0                 |
// +----------------------------------------------------------------------------+
module ud_bounded_counter #(
    parameter int                     NUM_CNT_BITS = 21,
    parameter logic [NUM_CNT_BITS-1:0] RESET_VAL   = '0,
    parameter bit                     SATURATE     = 1'b0
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load_en,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    up_en,
    input  logic                    down_en,
    input  logic [NUM_CNT_BITS-1:0] step,
    input  logic [NUM_CNT_BITS-1:0] min_val,
    input  logic [NUM_CNT_BITS-1:0] max_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    at_max,
    output logic                    at_min,
    output logic                    wrap_pulse,
    output logic                    cfg_err
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;
    logic                    wrap_q;
    logic                    wrap_d;

    // One extra bit keeps the carry of the sum and the borrow of the difference.
    logic [NUM_CNT_BITS:0]   w_sum;
    logic [NUM_CNT_BITS:0]   w_diff;
    logic [NUM_CNT_BITS-1:0] w_load_clamped;
    logic                    w_below;
    logic                    w_above;
    logic                    w_count_op;

    assign w_sum      = {1'b0, count_q} + {1'b0, step};
    assign w_diff     = {1'b0, count_q} - {1'b0, step};
    assign w_below    = (count_q < min_val);
    assign w_above    = (count_q > max_val);
    assign w_count_op = (up_en ^ down_en) && (step != '0);

    assign w_load_clamped = (load_val < min_val) ? min_val :
                            (load_val > max_val) ? max_val : load_val;

    assign cfg_err = (min_val > max_val);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = RESET_VAL;
        end else if (!cfg_err) begin
            if (load_en) begin
                count_d = w_load_clamped;
            end else if (w_count_op) begin
                // An out-of-range count is first pulled to the nearest bound, silently.
                if (w_below) begin
                    count_d = min_val;
                end else if (w_above) begin
                    count_d = max_val;
                end else if (up_en) begin
                    if (w_sum <= {1'b0, max_val}) begin
                        count_d = w_sum[NUM_CNT_BITS-1:0];
                    end else begin
                        count_d = SATURATE ? max_val : min_val;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    if (!w_diff[NUM_CNT_BITS] && (w_diff[NUM_CNT_BITS-1:0] >= min_val)) begin
                        count_d = w_diff[NUM_CNT_BITS-1:0];
                    end else begin
                        count_d = SATURATE ? min_val : max_val;
                        wrap_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= RESET_VAL;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_out  = count_q;
    assign wrap_pulse = wrap_q;
    assign at_max     = (count_q == max_val);
    assign at_min     = (count_q == min_val);

endmodule
`default_nettype wire
